// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and default sizes
// shared by every file of the alu_pipe block.
package alu_pkg;

   localparam int DEF_WIDTH    = 16;
   localparam int DEF_CSLA_BLK = 4;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_OR  = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_MUL_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: request/response handshake bundle
// between an ALU client (master) and alu_pipe (slave).
interface alu_pipe_if #(
   parameter int WIDTH = 16
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       opcode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             Cout;
   logic             zero;
   logic             ovf;
   logic             err;

   modport master (
      output in_valid, A, B, opcode, out_ready,
      input  in_ready, out_valid, result,
      input  Cout, zero, ovf, err
   );

   modport slave (
      input  in_valid, A, B, opcode, out_ready,
      output in_ready, out_valid, result,
      output Cout, zero, ovf, err
   );

endinterface

// File: rtl/csla_adder.sv
// csla_adder: carry-select adder; each block precomputes
// sums for carry-in 0 and 1 and the ripple only selects.
module csla_adder import alu_pkg::*; #(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int CSLA_BLK = DEF_CSLA_BLK
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NBLK = WIDTH / CSLA_BLK;

   logic [NBLK:0] carry;

   assign carry[0] = cin;

   for (genvar i = 0; i < NBLK; i++) begin : g_blk
      logic [CSLA_BLK:0] s0;
      logic [CSLA_BLK:0] s1;

      assign s0 = {1'b0, a[i*CSLA_BLK +: CSLA_BLK]}
                + {1'b0, b[i*CSLA_BLK +: CSLA_BLK]};
      assign s1 = s0 + {{CSLA_BLK{1'b0}}, 1'b1};

      assign sum[i*CSLA_BLK +: CSLA_BLK] =
         carry[i] ? s1[CSLA_BLK-1:0] : s0[CSLA_BLK-1:0];
      assign carry[i+1] =
         carry[i] ? s1[CSLA_BLK] : s0[CSLA_BLK];
   end

   assign cout = carry[NBLK];

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: one-deep ALU with 1-cycle ops; define ALU_MUL_EN
// to add a WIDTH-cycle shift-add multiplier (opcode 8).
module alu_pipe import alu_pkg::*; #(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int CSLA_BLK = DEF_CSLA_BLK
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       Enable,
   alu_pipe_if.slave  bus
);

   logic             idle;
   logic             accept;
   logic             alu_load;
   logic             mul_load;
   logic             load;
   logic             shift_big;

   logic [WIDTH-1:0] add_b;
   logic             add_cin;
   logic [WIDTH-1:0] add_sum;
   logic             add_cout;

   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;
   logic             alu_e;

   logic [WIDTH-1:0] mul_res;
   logic             mul_c;

   logic [WIDTH-1:0] ld_res;
   logic             ld_c;
   logic             ld_v;
   logic             ld_e;

   logic             out_valid_q;
   logic [WIDTH-1:0] res_q;
   logic             c_q;
   logic             z_q;
   logic             v_q;
   logic             e_q;

   assign bus.in_ready = Enable & idle
                       & (~out_valid_q | bus.out_ready);
   assign accept    = bus.in_valid & bus.in_ready;
   assign shift_big = bus.B >= WIDTH'(WIDTH);

   // SUB reuses the adder as A + ~B + 1.
   always_comb begin
      add_b   = bus.B;
      add_cin = 1'b0;
      if (bus.opcode == OP_SUB) begin
         add_b   = ~bus.B;
         add_cin = 1'b1;
      end
   end

   csla_adder #(
      .WIDTH    (WIDTH),
      .CSLA_BLK (CSLA_BLK)
   ) u_add (
      .a    (bus.A),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Single-cycle datapath; unknown opcodes give err, result 0.
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_e   = 1'b0;
      unique case (bus.opcode)
         OP_ADD, OP_SUB: begin
            alu_res = add_sum;
            alu_c   = add_cout;
            alu_v   = (bus.A[WIDTH-1] == add_b[WIDTH-1])
                    & (add_sum[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_OR:   alu_res = bus.A | bus.B;
         OP_AND:  alu_res = bus.A & bus.B;
         OP_XOR:  alu_res = bus.A ^ bus.B;
         OP_NOT:  alu_res = ~bus.A;
         OP_SHL:  alu_res = shift_big ? '0 : bus.A << bus.B;
         OP_SHR:  alu_res = shift_big ? '0 : bus.A >> bus.B;
         default: alu_e   = 1'b1;
      endcase
   end

`ifdef ALU_MUL_EN
   localparam int CNT_W = $clog2(WIDTH);

   state_t               state;
   state_t               state_nx;
   logic [CNT_W-1:0]     cnt;
   logic [2*WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   acc_nx;
   logic [WIDTH-1:0]     mplier;
   logic                 mul_go;
   logic                 last;
   logic                 mul_step;

   assign idle     = (state == ST_IDLE);
   assign mul_go   = accept & (bus.opcode == OP_MUL);
   assign alu_load = accept & ~mul_go;
   assign last     = (cnt == CNT_W'(WIDTH - 1));
   // The final step waits for a free output slot so a
   // result still being held is never overwritten.
   assign mul_step = Enable & ~idle
                   & ~(last & out_valid_q & ~bus.out_ready);
   assign mul_load = mul_step & last;
   assign acc_nx   = mplier[0] ? acc + mcand : acc;
   assign mul_res  = acc_nx[WIDTH-1:0];
   assign mul_c    = |acc_nx[2*WIDTH-1:WIDTH];

   // Multiplier FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Multiplier FSM next state.
   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:     if (mul_go)   state_nx = ST_MUL_BUSY;
         ST_MUL_BUSY: if (mul_load) state_nx = ST_IDLE;
      endcase
   end

   // Shift-add datapath: one partial product per busy step.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else if (mul_go) begin
         cnt    <= '0;
         mcand  <= {{WIDTH{1'b0}}, bus.A};
         mplier <= bus.B;
         acc    <= '0;
      end else if (mul_step) begin
         cnt    <= last ? '0 : cnt + CNT_W'(1);
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         acc    <= acc_nx;
      end
   end
`else
   assign idle     = 1'b1;
   assign alu_load = accept;
   assign mul_load = 1'b0;
   assign mul_res  = '0;
   assign mul_c    = 1'b0;
`endif

   assign load   = alu_load | mul_load;
   assign ld_res = mul_load ? mul_res : alu_res;
   assign ld_c   = mul_load ? mul_c   : alu_c;
   assign ld_v   = mul_load ? 1'b0    : alu_v;
   assign ld_e   = mul_load ? 1'b0    : alu_e;

   // Output register; a load beats a drain so no bubble.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         res_q       <= '0;
         c_q         <= 1'b0;
         z_q         <= 1'b0;
         v_q         <= 1'b0;
         e_q         <= 1'b0;
      end else if (Enable) begin
         if (load) begin
            out_valid_q <= 1'b1;
            res_q       <= ld_res;
            c_q         <= ld_c;
            z_q         <= (ld_res == '0);
            v_q         <= ld_v;
            e_q         <= ld_e;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.result    = res_q;
   assign bus.Cout      = c_q;
   assign bus.zero      = z_q;
   assign bus.ovf       = v_q;
   assign bus.err       = e_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench; expected results are queued
// at accept and popped by a monitor at each output drain.
module tb_alu_pipe;
   import alu_pkg::*;

   localparam int W = 16;
   localparam longint MAXU = (longint'(1) << W) - 1;
   localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
   localparam longint MINS = -(longint'(1) << (W - 1));
`ifdef ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0] res;
      logic         c;
      logic         z;
      logic         v;
      logic         e;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic Enable;
   bit   rand_mode = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t sb[$];

   alu_pipe_if #(.WIDTH(W)) bus ();

   alu_pipe #(
      .WIDTH    (W),
      .CSLA_BLK (4)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .Enable (Enable),
      .bus    (bus)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the operands.
   function automatic exp_t model(input logic [3:0] op,
                                  input logic [W-1:0] a,
                                  input logic [W-1:0] b);
      longint ua, ub, sa, sb_, r;
      exp_t e;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb_ = longint'($signed(b));
      e = '0;
      case (op)
         4'd0: begin
            r = ua + ub;
            e.res = W'(r);
            e.c = (r > MAXU);
            e.v = (sa + sb_ > MAXS) || (sa + sb_ < MINS);
         end
         4'd1: begin
            e.res = W'(ua - ub);
            e.c = (ua >= ub);
            e.v = (sa - sb_ > MAXS) || (sa - sb_ < MINS);
         end
         4'd2: e.res = a | b;
         4'd3: e.res = a & b;
         4'd4: e.res = a ^ b;
         4'd5: e.res = ~a;
         4'd6: e.res = (ub >= W) ? '0 : W'(ua << ub);
         4'd7: e.res = (ub >= W) ? '0 : W'(ua >> ub);
         4'd8: begin
            if (MUL_EN) begin
               r = ua * ub;
               e.res = W'(r);
               e.c = ((r >> W) != 0);
            end else begin
               e.e = 1'b1;
            end
         end
         default: e.e = 1'b1;
      endcase
      e.z = (e.res == '0);
      return e;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return '1;
         2: return 16'h7FFF;
         3: return 16'h8000;
         4: return 16'h0001;
         default: return W'($urandom);
      endcase
   endfunction

   // Call at posedge+1; returns at posedge+1 after the accept edge.
   task automatic send(input logic [3:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       output int waited);
      waited = 0;
      bus.in_valid = 1'b1;
      bus.opcode = op;
      bus.A = a;
      bus.B = b;
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         waited++;
         if (waited > 1000) break;
      end
      if (waited > 1000) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout: got no in_ready, want one");
      end else begin
         sb.push_back(model(op, a, b));
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n, output exp_t v);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.out_valid && n < 200);
      v = {bus.result, bus.Cout, bus.zero, bus.ovf, bus.err};
      @(posedge clk);
      #1;
   endtask

   task automatic dir(input string name, input logic [3:0] op,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input int lat, input exp_t want);
      int w, n;
      exp_t v;
      send(op, a, b, w);
      wait_valid(n, v);
      chk({name, "_lat"}, n, lat);
      chk(name, v, want);
   endtask

   // Random consumer back-pressure and global stalls.
   always @(posedge clk) begin
      if (rand_mode) begin
         #1;
         bus.out_ready = ($urandom_range(0, 3) != 0);
         Enable = ($urandom_range(0, 7) != 0);
      end
   end

   // Monitor: pop and compare on drain, check stability on hold.
   always @(negedge clk) begin
      exp_t got, e;
      static exp_t held = '0;
      static bit held_v = 1'b0;
      if (!rst_n) begin
         held_v = 1'b0;
      end else begin
         got = {bus.result, bus.Cout, bus.zero, bus.ovf, bus.err};
         if (held_v && bus.out_valid) chk("hold_stable", got, held);
         if (bus.out_valid && bus.out_ready && Enable) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_out: got %h, want none", got);
            end else begin
               e = sb.pop_front();
               chk("result", got, e);
            end
         end
         held_v = bus.out_valid && !(bus.out_ready && Enable);
         held = got;
      end
   end

   // Watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "timeout");
   end

   // Stimulus.
   initial begin
      int w, n;
      exp_t v;
      logic [3:0] op;
      logic [W-1:0] a, b;
      rst_n = 1'b0;
      Enable = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      bus.opcode = '0;
      bus.A = '0;
      bus.B = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_state", {bus.out_valid, bus.result, bus.Cout,
                        bus.zero, bus.ovf, bus.err}, 32'h0);
      chk("rst_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      dir("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 1, {16'h8000, 4'b0010});
      dir("sub_neg", OP_SUB, 16'h0003, 16'h0008, 1, {16'hFFFB, 4'b0000});
      dir("sub_pos", OP_SUB, 16'h0008, 16'h0003, 1, {16'h0005, 4'b1000});
      dir("shr15", OP_SHR, 16'h8000, 16'd15, 1, {16'h0001, 4'b0000});
      dir("shl16", OP_SHL, 16'h0001, 16'd16, 1, {16'h0000, 4'b0100});
      dir("illegal", 4'hC, 16'h1234, 16'h5678, 1, {16'h0000, 4'b0101});

      bus.out_ready = 1'b0;
      send(OP_ADD, 16'd5, 16'd3, w);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_res", {bus.out_valid, bus.result}, {1'b1, 16'h0008});
         chk("hold_in_ready", bus.in_ready, 0);
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      send(OP_XOR, 16'h00F0, 16'h0FF0, w);
      chk("b2b_wait", w, 0);
      @(negedge clk);
      chk("b2b_out", {bus.out_valid, bus.result}, {1'b1, 16'h0F00});
      @(posedge clk);
      #1;

`ifdef ALU_MUL_EN
      dir("mul", OP_MUL, 16'h0100, 16'h0100, 17, {16'h0000, 4'b1100});
      send(OP_MUL, 16'h1234, 16'h0042, w);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_ready", bus.in_ready, 1);
      chk("abort_valid", bus.out_valid, 0);
      @(posedge clk);
      #1;
      send(OP_MUL, 16'h0003, 16'h0005, w);
      fork
         begin
            repeat (3) @(posedge clk);
            #1;
            Enable = 1'b0;
            @(negedge clk);
            chk("stall_in_ready", bus.in_ready, 0);
            repeat (4) @(posedge clk);
            #1;
            Enable = 1'b1;
         end
      join_none
      wait_valid(n, v);
      chk("mul_stall_lat", n, 21);
      chk("mul_stall", v, {16'h000F, 4'b0000});
`else
      dir("mul_off", OP_MUL, 16'h0003, 16'h0004, 1, {16'h0000, 4'b0101});
`endif

      rand_mode = 1'b1;
      for (int i = 0; i < 300; i++) begin
         op = 4'($urandom_range(0, 15));
         a = pick();
         b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20))
                                         : pick();
         send(op, a, b, w);
         if ($urandom_range(0, 4) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      rand_mode = 1'b0;
      @(posedge clk);
      #1;
      Enable = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("drain_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
